// File: rtl/led_pkg.sv
// Shared encodings and default step lengths for the LED pattern engine.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROR    = 2'b00,
    MODE_ROL    = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  // Step lengths in clk_in cycles at 5 MHz.
  localparam int STEP0_DEF = 1_000_000;
  localparam int STEP1_DEF = 1_750_000;
  localparam int STEP2_DEF = 2_500_000;
  localparam int STEP3_DEF = 5_000_000;

endpackage

// File: rtl/led_pattern_gen_step_tick.sv
// Speed-selectable step divider; a speed change restarts the count from zero.
module step_tick #(
  parameter int CNT_W = 23,
  parameter int STEP0 = 1_000_000,
  parameter int STEP1 = 1_750_000,
  parameter int STEP2 = 2_500_000,
  parameter int STEP3 = 5_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic       run,
  output logic       tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sel_last;
  logic [1:0]       prev_speed;
  logic             speed_chg;

  always_comb begin
    sel_last = CNT_W'(STEP0 - 1);
    case (speed)
      2'd0: sel_last = CNT_W'(STEP0 - 1);
      2'd1: sel_last = CNT_W'(STEP1 - 1);
      2'd2: sel_last = CNT_W'(STEP2 - 1);
      2'd3: sel_last = CNT_W'(STEP3 - 1);
      default: sel_last = CNT_W'(STEP0 - 1);
    endcase
  end

  assign speed_chg = (speed != prev_speed);
  // Tick is decoded from the current count so the pattern updates on the same edge.
  assign tick      = run && !speed_chg && (cnt == sel_last);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt        <= '0;
      prev_speed <= speed;
    end else begin
      prev_speed <= speed;
      if (speed_chg || tick) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: rotate, toggle-sweep and bounce patterns advanced by step_tick.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED = 4,
  parameter int CNT_W = 23,
  parameter int STEP0 = STEP0_DEF,
  parameter int STEP1 = STEP1_DEF,
  parameter int STEP2 = STEP2_DEF,
  parameter int STEP3 = STEP3_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             run,
  output logic [N_LED-1:0] led,
  output logic             step_o
);

  localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LED - 1);
  localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1);

  logic             tick;
  logic [IDX_W-1:0] idx, idx_cur, idx_nxt;
  dir_e             dir, dir_cur, dir_nxt;
  logic [1:0]       prev_mode;
  logic             mode_chg;
  logic [N_LED-1:0] led_nxt;

  step_tick #(
    .CNT_W (CNT_W),
    .STEP0 (STEP0),
    .STEP1 (STEP1),
    .STEP2 (STEP2),
    .STEP3 (STEP3)
  ) u_step_tick (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .speed  (speed),
    .run    (run),
    .tick   (tick)
  );

  assign mode_chg = (mode != prev_mode);
  // A mode change re-arms sweep/bounce state before any coincident tick uses it.
  assign idx_cur  = mode_chg ? IDX_LAST : idx;
  assign dir_cur  = mode_chg ? LEFT : dir;

  always_comb begin
    led_nxt = led;
    idx_nxt = idx_cur;
    dir_nxt = dir_cur;
    if (tick) begin
      case (mode_e'(mode))
        MODE_ROR: led_nxt = {led[0], led[N_LED-1:1]};
        MODE_ROL: led_nxt = {led[N_LED-2:0], led[N_LED-1]};
        MODE_SWEEP: begin
          led_nxt = led ^ (LED_ONE << idx_cur);
          idx_nxt = (idx_cur == '0) ? IDX_LAST : idx_cur - IDX_W'(1);
        end
        MODE_BOUNCE: begin
          if (led == '0) begin
            led_nxt = LED_ONE;
            dir_nxt = LEFT;
          end else if (dir_cur == LEFT) begin
            if (led[N_LED-1]) begin
              dir_nxt = RIGHT;
              led_nxt = led >> 1;
            end else begin
              led_nxt = led << 1;
            end
          end else begin
            if (led[0]) begin
              dir_nxt = LEFT;
              led_nxt = led << 1;
            end else begin
              led_nxt = led >> 1;
            end
          end
        end
        default: led_nxt = led;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      led       <= LED_ONE;
      step_o    <= 1'b0;
      idx       <= IDX_LAST;
      dir       <= LEFT;
      prev_mode <= mode;
    end else begin
      led       <= led_nxt;
      step_o    <= tick;
      idx       <= idx_nxt;
      dir       <= dir_nxt;
      prev_mode <= mode;
    end
  end

endmodule
